// File: rtl/icache_refill_unit.sv
// icache_refill_unit: on an instruction-cache miss, reads the missing block one word at a time
// from memory. It then writes the assembled block, line index and tag into the cache array in
// a single cycle.
module icache_refill_unit #(
  parameter int unsigned offset_width = 2,
  parameter int unsigned line_width   = 6,
  localparam int unsigned block_size  = 1 << offset_width,
  localparam int unsigned tag_width   = 30 - offset_width - line_width
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [31:0]               miss_address,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [31:0]               mem_req_address,
  input  logic                      mem_resp_valid,
  output logic                      mem_resp_ready,
  input  logic [31:0]               mem_resp_data,
  input  logic                      invalidate_all,
  output logic                      write_in,
  output logic [line_width-1:0]     write_line_index,
  output logic [32*block_size-1:0]  write_block,
  output logic [tag_width-1:0]      write_tag,
  output logic                      refill_done,
  output logic                      busy
);

  localparam int unsigned cnt_width = offset_width + 1;
  localparam int unsigned low_bits  = offset_width + 2;
  localparam logic [cnt_width-1:0] block_count = cnt_width'(block_size);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_t;

  state_t               state;
  logic [31:0]          base;
  logic [cnt_width-1:0] issue_cnt;
  logic [cnt_width-1:0] recv_cnt;
  logic                 poison;

  // Byte offset within the block is implied by the word counters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_address[low_bits-1:0];

  // Handshake and strobe outputs decoded straight from registered state.
  always_comb begin
    miss_ready      = (state == StIdle);
    busy            = (state != StIdle);
    mem_req_valid   = (state == StFetch) && (issue_cnt < block_count);
    mem_req_address = base + 32'({issue_cnt, 2'b00});
    // Never accept more responses than requests issued.
    mem_resp_ready  = (state == StFetch) && (recv_cnt < issue_cnt);
    refill_done     = (state == StWrite);
    // A flush in the write cycle itself must also suppress the write.
    write_in        = (state == StWrite) && !poison && !invalidate_all;
  end

  // Refill FSM: latch the miss, stream words in, then one write cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= StIdle;
      base             <= '0;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      poison           <= 1'b0;
      write_line_index <= '0;
      write_tag        <= '0;
      write_block      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (miss_valid) begin
            base             <= {miss_address[31:low_bits], {low_bits{1'b0}}};
            write_line_index <= miss_address[line_width+low_bits-1:low_bits];
            write_tag        <= miss_address[31:line_width+low_bits];
            issue_cnt        <= '0;
            recv_cnt         <= '0;
            poison           <= 1'b0;
            state            <= StFetch;
          end
        end
        StFetch: begin
          // A flush mid-refill lets the memory traffic finish but drops the write.
          if (invalidate_all) begin
            poison <= 1'b1;
          end
          if (mem_req_valid && mem_req_ready) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (mem_resp_valid && mem_resp_ready) begin
            write_block[32*recv_cnt[offset_width-1:0] +: 32] <= mem_resp_data;
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == block_count - 1'b1) begin
              state <= StWrite;
            end
          end
        end
        StWrite: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit: table-driven refills, hand-written corner
// sequences and randomized traffic, all compared cycle by cycle with a behavioural model.
module tb_icache_refill_unit;

  localparam int BlockSize = 4;
  localparam int LineWidth = 6;
  localparam int TagWidth  = 22;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     miss_valid;
  logic                     miss_ready;
  logic [31:0]              miss_address;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [31:0]              mem_req_address;
  logic                     mem_resp_valid;
  logic                     mem_resp_ready;
  logic [31:0]              mem_resp_data;
  logic                     invalidate_all;
  logic                     write_in;
  logic [LineWidth-1:0]     write_line_index;
  logic [32*BlockSize-1:0]  write_block;
  logic [TagWidth-1:0]      write_tag;
  logic                     refill_done;
  logic                     busy;

  always #5 clock = ~clock;

  icache_refill_unit dut (
    .clock            (clock),
    .reset            (reset),
    .miss_valid       (miss_valid),
    .miss_ready       (miss_ready),
    .miss_address     (miss_address),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_address  (mem_req_address),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_ready   (mem_resp_ready),
    .mem_resp_data    (mem_resp_data),
    .invalidate_all   (invalidate_all),
    .write_in         (write_in),
    .write_line_index (write_line_index),
    .write_block      (write_block),
    .write_tag        (write_tag),
    .refill_done      (refill_done),
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory model: in-order queue of accepted requests with a ready-at cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       mq[$];
  int          req_mode  = 0;   // 0 always ready, 1 toggling, 2 random
  int          max_delay = 1;
  logic [31:0] data_key  = '0;
  bit          junk_en   = 1'b0;

  // Reference model of the refill, kept as a word array and counts.
  bit          m_active, m_wr, m_poison;
  int          m_iss, m_rcv;
  logic [31:0] m_base;
  logic [5:0]  m_line;
  logic [21:0] m_tag;
  logic [31:0] m_words[BlockSize];

  // Observation logs.
  int           n_req, n_write, n_done;
  int           acc_log[$];
  int           wr_log[$];
  logic [21:0]  wr_tag_log[$];
  logic [5:0]   wr_line_log[$];
  logic [127:0] wr_blk_log[$];
  logic [31:0]  req_log[$];

  task automatic clear_logs();
    n_req = 0; n_write = 0; n_done = 0;
    acc_log.delete(); wr_log.delete(); wr_tag_log.delete();
    wr_line_log.delete(); wr_blk_log.delete(); req_log.delete();
  endtask

  task automatic model_reset();
    m_active = 0; m_wr = 0; m_poison = 0; m_iss = 0; m_rcv = 0;
    m_base = '0; m_line = '0; m_tag = '0;
    for (int j = 0; j < BlockSize; j++) m_words[j] = '0;
  endtask

  // One clock cycle: drive memory inputs, compare at negedge+1, advance models over the edge.
  task automatic step();
    logic         e_req_v, e_resp_r, e_wi;
    logic [127:0] e_blk;
    case (req_mode)
      0:       mem_req_ready = 1'b1;
      1:       mem_req_ready = (cyc % 2 == 0);
      default: mem_req_ready = 1'($urandom_range(0, 1));
    endcase
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mq[0].addr ^ data_key;
    end else begin
      mem_resp_valid = junk_en && (mq.size() == 0) && ($urandom_range(0, 3) == 0);
      mem_resp_data  = $urandom;
    end
    #1;
    e_req_v  = m_active && !m_wr && (m_iss < BlockSize);
    e_resp_r = m_active && !m_wr && (m_rcv < m_iss);
    e_wi     = m_wr && !m_poison && !invalidate_all;
    for (int j = 0; j < BlockSize; j++) e_blk[32*j +: 32] = m_words[j];
    chk("miss_ready", miss_ready, !m_active);
    chk("busy", busy, m_active);
    chk("mem_req_valid", mem_req_valid, e_req_v);
    chk("mem_resp_ready", mem_resp_ready, e_resp_r);
    chk("refill_done", refill_done, m_wr);
    chk("write_in", write_in, e_wi);
    chk("write_line_index", write_line_index, m_line);
    chk("write_tag", write_tag, m_tag);
    chk("write_block", write_block, e_blk);
    if (e_req_v) chk("mem_req_address", mem_req_address, m_base + 32'(4 * m_iss));

    if (mem_req_valid && mem_req_ready) begin
      n_req++;
      req_log.push_back(mem_req_address);
    end
    if (refill_done) n_done++;
    if (write_in) begin
      n_write++;
      wr_log.push_back(cyc);
      wr_tag_log.push_back(write_tag);
      wr_line_log.push_back(write_line_index);
      wr_blk_log.push_back(write_block);
    end
    if (miss_valid && miss_ready && !reset) acc_log.push_back(cyc);

    if (reset) begin
      mq.delete();
    end else begin
      if (mem_resp_valid && mem_resp_ready && mq.size() > 0) void'(mq.pop_front());
      if (mem_req_valid && mem_req_ready)
        mq.push_back('{addr: mem_req_address, due: cyc + $urandom_range(1, max_delay)});
    end

    if (reset) begin
      model_reset();
    end else if (!m_active) begin
      if (miss_valid) begin
        m_active = 1; m_iss = 0; m_rcv = 0; m_poison = 0;
        m_base   = {miss_address[31:4], 4'b0};
        m_line   = miss_address[9:4];
        m_tag    = miss_address[31:10];
      end
    end else if (m_wr) begin
      m_active = 0;
      m_wr     = 0;
    end else begin
      if (invalidate_all) m_poison = 1;
      if (e_req_v && mem_req_ready) m_iss++;
      if (e_resp_r && mem_resp_valid) begin
        m_words[m_rcv] = mem_resp_data;
        m_rcv++;
        if (m_rcv == BlockSize) m_wr = 1;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_miss(input logic [31:0] addr);
    bit acc = 0;
    int k   = 0;
    miss_valid   = 1'b1;
    miss_address = addr;
    while (!acc && k < 50) begin
      acc = miss_ready;
      step();
      k++;
    end
    miss_valid = 1'b0;
    chk("miss_accept_timeout", acc, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      step();
      k++;
    end
    chk("refill_timeout", busy, 1'b0);
  endtask

  function automatic logic [127:0] block_of(input logic [31:0] base);
    logic [127:0] b;
    for (int j = 0; j < BlockSize; j++) b[32*j +: 32] = base + 32'(4 * j);
    return b;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    logic [5:0]  line;
    logic [21:0] tag;
  } vec_t;

  vec_t vt[4];

  initial begin
    // tag = addr[31:10], line = addr[9:4], base = addr with low 4 bits cleared
    vt[0] = '{addr: 32'h0000_1234, base: 32'h0000_1230, line: 6'h23, tag: 22'h000004};
    vt[1] = '{addr: 32'hFFFF_FFF0, base: 32'hFFFF_FFF0, line: 6'h3F, tag: 22'h3FFFFF};
    vt[2] = '{addr: 32'h0000_0000, base: 32'h0000_0000, line: 6'h00, tag: 22'h000000};
    vt[3] = '{addr: 32'hABCD_EF0B, base: 32'hABCD_EF00, line: 6'h30, tag: 22'h2AF37B};

    reset = 1'b1; miss_valid = 1'b0; miss_address = '0; invalidate_all = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    step();
    step();

    // Zero-wait refills from the table.
    foreach (vt[i]) begin
      req_mode = 0; max_delay = 1; data_key = '0;
      clear_logs();
      do_miss(vt[i].addr);
      wait_idle(40);
      chk("tbl_requests", n_req, 4);
      chk("tbl_writes", n_write, 1);
      chk("tbl_latency", wr_log[0] - acc_log[0], 6);
      chk("tbl_line", wr_line_log[0], vt[i].line);
      chk("tbl_tag", wr_tag_log[0], vt[i].tag);
      chk("tbl_block", wr_blk_log[0], block_of(vt[i].base));
      chk("tbl_first_req", req_log[0], vt[i].base);
    end

    // Backpressure on both sides.
    req_mode = 1; max_delay = 3;
    clear_logs();
    do_miss(32'h0000_1234);
    wait_idle(80);
    chk("bp_requests", n_req, 4);
    chk("bp_writes", n_write, 1);
    chk("bp_block", wr_blk_log[0], block_of(32'h0000_1230));

    // Flush after the second response: refill completes but is dropped.
    req_mode = 0; max_delay = 2;
    clear_logs();
    do_miss(32'h2000_0040);
    for (int k = 0; k < 30 && m_rcv < 2; k++) step();
    invalidate_all = 1'b1;
    step();
    invalidate_all = 1'b0;
    wait_idle(40);
    chk("flush_fetch_writes", n_write, 0);
    chk("flush_fetch_done", n_done, 1);
    clear_logs();
    do_miss(32'h2000_0040);
    wait_idle(40);
    chk("after_flush_writes", n_write, 1);
    chk("after_flush_block", wr_blk_log[0], block_of(32'h2000_0040));

    // Flush exactly in the write cycle.
    clear_logs();
    do_miss(32'h0000_5670);
    for (int k = 0; k < 30 && !refill_done; k++) step();
    invalidate_all = 1'b1;
    step();
    invalidate_all = 1'b0;
    wait_idle(10);
    chk("flush_write_writes", n_write, 0);
    chk("flush_write_done", n_done, 1);

    // Reset after two requests, then a refill at the top of memory.
    req_mode = 0; max_delay = 1;
    clear_logs();
    do_miss(32'h0000_1234);
    for (int k = 0; k < 20 && n_req < 2; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    clear_logs();
    do_miss(32'hFFFF_FFF0);
    wait_idle(40);
    chk("rst_req_count", req_log.size(), 4);
    for (int j = 0; j < 4; j++) chk("rst_req_addr", req_log[j], 32'hFFFF_FFF0 + 32'(4 * j));
    chk("rst_tag", wr_tag_log[0], 22'h3FFFFF);
    chk("rst_line", wr_line_log[0], 6'h3F);

    // Back-to-back misses with miss_valid held high.
    clear_logs();
    miss_valid   = 1'b1;
    miss_address = 32'h0000_1234;
    for (int k = 0; k < 20 && acc_log.size() < 1; k++) step();
    miss_address = 32'h0001_0800;
    for (int k = 0; k < 40 && acc_log.size() < 2; k++) step();
    miss_valid = 1'b0;
    wait_idle(40);
    chk("b2b_writes", wr_log.size(), 2);
    chk("b2b_accept_gap", acc_log[1], wr_log[0] + 1);
    chk("b2b_tag0", wr_tag_log[0], 22'h000004);
    chk("b2b_tag1", wr_tag_log[1], 22'h000042);

    // Randomized traffic against the model.
    req_mode = 2; max_delay = 3; data_key = $urandom; junk_en = 1'b1;
    clear_logs();
    for (int k = 0; k < 3000; k++) begin
      miss_valid     = ($urandom_range(0, 3) != 0);
      miss_address   = $urandom;
      invalidate_all = ($urandom_range(0, 15) == 0);
      reset          = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; miss_valid = 1'b0; invalidate_all = 1'b0; junk_en = 1'b0;
    wait_idle(80);
    chk("random_progress", n_write > 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
